// File: rtl/npc_pkg.sv
// Shared types and constants for the npc core writeback path.
package npc_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic {
        WB_RUN  = 1'b0,
        WB_HALT = 1'b1
    } wb_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] ld_align_mask(input ld_size_e size);
        case (size)
            LD_B:    return 3'b000;
            LD_H:    return 3'b001;
            LD_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: picks the addressed byte/half/word/double from the raw
// doubleword and sign- or zero-extends it. Misaligned offsets round down.
module wb_load_align
    import npc_pkg::*;
(
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      addr_lo_i,
    input  ld_size_e        size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] value_o,
    output logic            misaligned_o
);

    logic [2:0]      mask;
    logic [2:0]      offset;
    logic [XLEN-1:0] shifted;
    logic            sext;

    always_comb begin
        mask         = ld_align_mask(size_i);
        offset       = addr_lo_i & ~mask;
        misaligned_o = |(addr_lo_i & mask);
        shifted      = raw_i >> {offset, 3'b000};
        sext         = 1'b0;
        value_o      = '0;
        case (size_i)
            LD_B: begin
                sext    = ~unsigned_i & shifted[7];
                value_o = {{56{sext}}, shifted[7:0]};
            end
            LD_H: begin
                sext    = ~unsigned_i & shifted[15];
                value_o = {{48{sext}}, shifted[15:0]};
            end
            LD_W: begin
                sext    = ~unsigned_i & shifted[31];
                value_o = {{32{sext}}, shifted[31:0]};
            end
            default: value_o = shifted;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-entry WB register feeding the register-file write port.
// Build option WB_FWD_EN exposes the pending write as a decode forwarding source.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   WB_RUN  | accepting and retiring instructions
//   WB_HALT | ebreak retired; frozen until reset
module wb_stage
    import npc_pkg::ld_size_e, npc_pkg::wb_state_e, npc_pkg::WB_RUN,
           npc_pkg::WB_HALT, npc_pkg::REG_ZERO;
#(
    parameter int unsigned XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_is_load,
    input  logic [1:0]      in_ld_size,
    input  logic            in_ld_unsigned,
    input  logic [2:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_ld_data,
    input  logic            in_ebreak,
    input  logic            hold,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [63:0]     instret,
    output logic            halted,
    output logic [XLEN-1:0] halt_pc,
    output logic            ld_misaligned
);

    wb_state_e       state_q, state_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_pc_q, wb_pc_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_rd_wen_q, wb_rd_wen_d;
    logic            wb_ebreak_q, wb_ebreak_d;
    logic [XLEN-1:0] wb_value_q, wb_value_d;
    logic [63:0]     instret_q, instret_d;
    logic [XLEN-1:0] halt_pc_q, halt_pc_d;
    logic            ld_mis_q, ld_mis_d;

    logic [XLEN-1:0] ld_value;
    logic            ld_mis;
    logic            retire;
    logic            accept;

    wb_load_align u_load_align (
        .raw_i        (in_ld_data),
        .addr_lo_i    (in_addr_lo),
        .size_i       (ld_size_e'(in_ld_size)),
        .unsigned_i   (in_ld_unsigned),
        .value_o      (ld_value),
        .misaligned_o (ld_mis)
    );

    // A held or halting entry blocks the input so the single WB slot never overflows.
    assign in_ready = (state_q == WB_RUN) && !(wb_valid_q && wb_ebreak_q)
                      && !(wb_valid_q && hold);
    assign accept   = in_valid && in_ready;
    assign retire   = (state_q == WB_RUN) && wb_valid_q && !hold;

    always_comb begin
        state_d     = state_q;
        wb_valid_d  = wb_valid_q;
        wb_pc_d     = wb_pc_q;
        wb_rd_d     = wb_rd_q;
        wb_rd_wen_d = wb_rd_wen_q;
        wb_ebreak_d = wb_ebreak_q;
        wb_value_d  = wb_value_q;
        instret_d   = instret_q;
        halt_pc_d   = halt_pc_q;
        ld_mis_d    = ld_mis_q;

        if (retire) begin
            wb_valid_d = 1'b0;
            instret_d  = instret_q + 64'd1;
            if (wb_ebreak_q) begin
                state_d   = WB_HALT;
                halt_pc_d = wb_pc_q;
            end
        end

        if (accept) begin
            wb_valid_d  = 1'b1;
            wb_pc_d     = in_pc;
            wb_rd_d     = in_rd;
            wb_rd_wen_d = in_rd_wen;
            wb_ebreak_d = in_ebreak;
            wb_value_d  = in_is_load ? ld_value : in_result;
            if (in_is_load && ld_mis) begin
                ld_mis_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WB_RUN;
            wb_valid_q  <= 1'b0;
            wb_pc_q     <= '0;
            wb_rd_q     <= '0;
            wb_rd_wen_q <= 1'b0;
            wb_ebreak_q <= 1'b0;
            wb_value_q  <= '0;
            instret_q   <= '0;
            halt_pc_q   <= RESET_PC[XLEN-1:0];
            ld_mis_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_pc_q     <= wb_pc_d;
            wb_rd_q     <= wb_rd_d;
            wb_rd_wen_q <= wb_rd_wen_d;
            wb_ebreak_q <= wb_ebreak_d;
            wb_value_q  <= wb_value_d;
            instret_q   <= instret_d;
            halt_pc_q   <= halt_pc_d;
            ld_mis_q    <= ld_mis_d;
        end
    end

    assign rf_wen        = retire && wb_rd_wen_q && (wb_rd_q != REG_ZERO);
    assign rf_waddr      = retire ? wb_rd_q : '0;
    assign rf_wdata      = retire ? wb_value_q : '0;
    assign commit_valid  = retire;
    assign commit_pc     = retire ? wb_pc_q : '0;
    assign instret       = instret_q;
    assign halted        = (state_q == WB_HALT);
    assign halt_pc       = halt_pc_q;
    assign ld_misaligned = ld_mis_q;

`ifdef WB_FWD_EN
    assign fwd_valid = wb_valid_q && wb_rd_wen_q && (wb_rd_q != REG_ZERO);
    assign fwd_rd    = wb_rd_q;
    assign fwd_data  = wb_value_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random traffic
// compared against a transaction-level model of the writeback stage.
module tb_wb_stage;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [63:0] in_result;
    logic        in_is_load;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [2:0]  in_addr_lo;
    logic [63:0] in_ld_data;
    logic        in_ebreak;
    logic        hold;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [63:0] instret;
    logic        halted;
    logic [63:0] halt_pc;
    logic        ld_misaligned;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(64), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
        .in_rd_wen(in_rd_wen), .in_result(in_result), .in_is_load(in_is_load),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
        .in_ld_data(in_ld_data), .in_ebreak(in_ebreak), .hold(hold),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .instret(instret),
        .halted(halted), .halt_pc(halt_pc), .ld_misaligned(ld_misaligned)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] result;
        logic        is_load;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  alo;
        logic [63:0] ld;
        logic        ebreak;
    } ins_t;

    int checks = 0;
    int failures = 0;

    // Transaction-level model: at most one instruction waiting to retire.
    logic        m_pend;
    logic [63:0] m_pc;
    logic [4:0]  m_rd;
    logic        m_wen;
    logic        m_ebrk;
    logic [63:0] m_val;
    logic        m_halted;
    logic [63:0] m_halt_pc;
    logic [63:0] m_instret;
    logic        m_mis;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-wise extraction from the rounded-down offset, then extension.
    function automatic logic [63:0] ref_value(input ins_t x);
        int n, off;
        logic [63:0] v;
        if (!x.is_load) return x.result;
        n   = 1 << x.size;
        off = (int'(x.alo) / n) * n;
        v   = '0;
        for (int k = 0; k < n; k++)
            v = v | (64'(x.ld[8*(off+k) +: 8]) << (8*k));
        if (!x.uns && n < 8 && v[8*n-1])
            v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    function automatic logic ref_mis(input ins_t x);
        int n;
        n = 1 << x.size;
        return x.is_load && ((int'(x.alo) % n) != 0);
    endfunction

    function automatic ins_t idle_ins();
        ins_t x;
        x = '0;
        return x;
    endfunction

    function automatic ins_t rand_ins();
        ins_t x;
        x.pc      = {32'h0, $urandom} & ~64'd3;
        x.rd      = 5'($urandom_range(0, 31));
        x.rd_wen  = 1'($urandom_range(0, 3) != 0);
        x.result  = {$urandom, $urandom};
        x.is_load = 1'($urandom_range(0, 1));
        x.size    = 2'($urandom_range(0, 3));
        x.uns     = 1'($urandom_range(0, 1));
        x.alo     = 3'($urandom_range(0, 7));
        x.ld      = {$urandom, $urandom};
        x.ebreak  = ($urandom_range(0, 63) == 0);
        return x;
    endfunction

    task automatic drive(input logic v, input logic h, input ins_t x);
        in_valid       = v;
        hold           = h;
        in_pc          = x.pc;
        in_rd          = x.rd;
        in_rd_wen      = x.rd_wen;
        in_result      = x.result;
        in_is_load     = x.is_load;
        in_ld_size     = x.size;
        in_ld_unsigned = x.uns;
        in_addr_lo     = x.alo;
        in_ld_data     = x.ld;
        in_ebreak      = x.ebreak;
    endtask

    task automatic model_reset();
        m_pend    = 0;
        m_pc      = '0;
        m_rd      = '0;
        m_wen     = 0;
        m_ebrk    = 0;
        m_val     = '0;
        m_halted  = 0;
        m_halt_pc = RESET_PC;
        m_instret = '0;
        m_mis     = 0;
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, idle_ins());
        rst = 1'b0;
        #2;
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_rf_wen"}, rf_wen, 0);
        chk({tag, "_rf_waddr"}, rf_waddr, 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
        chk({tag, "_commit_valid"}, commit_valid, 0);
        chk({tag, "_commit_pc"}, commit_pc, 0);
        chk({tag, "_instret"}, instret, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_halt_pc"}, halt_pc, RESET_PC);
        chk({tag, "_ld_mis"}, ld_misaligned, 0);
        chk({tag, "_fwd_valid"}, fwd_valid, 0);
        chk({tag, "_fwd_data"}, fwd_data, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive, check the combinational view against the model, advance.
    task automatic step(input logic v, input logic h, input ins_t x, output logic acc);
        logic exp_ready, exp_commit, exp_fv;
        drive(v, h, x);
        #1;
        exp_ready  = !m_halted && !(m_pend && (m_ebrk || h));
        exp_commit = m_pend && !h && !m_halted;
        chk("in_ready", in_ready, exp_ready);
        chk("commit_valid", commit_valid, exp_commit);
        chk("rf_wen", rf_wen, exp_commit && m_wen && (m_rd != 0));
        if (exp_commit) begin
            chk("commit_pc", commit_pc, m_pc);
            chk("rf_waddr", rf_waddr, m_rd);
            chk("rf_wdata", rf_wdata, m_val);
        end
        chk("instret", instret, m_instret);
        chk("halted", halted, m_halted);
        chk("halt_pc", halt_pc, m_halt_pc);
        chk("ld_mis", ld_misaligned, m_mis);
        exp_fv = m_pend && m_wen && (m_rd != 0);
`ifdef WB_FWD_EN
        chk("fwd_valid", fwd_valid, exp_fv);
        if (exp_fv) begin
            chk("fwd_rd", fwd_rd, m_rd);
            chk("fwd_data", fwd_data, m_val);
        end
`else
        chk("fwd_valid", fwd_valid, 0);
        chk("fwd_rd", fwd_rd, 0);
        chk("fwd_data", fwd_data, 0);
`endif
        acc = v && exp_ready;
        if (exp_commit) begin
            m_instret = m_instret + 1;
            m_pend    = 0;
            if (m_ebrk) begin
                m_halted  = 1;
                m_halt_pc = m_pc;
            end
        end
        if (acc) begin
            m_pend = 1;
            m_pc   = x.pc;
            m_rd   = x.rd;
            m_wen  = x.rd_wen;
            m_ebrk = x.ebreak;
            m_val  = ref_value(x);
            if (ref_mis(x)) m_mis = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ins_t x;
        logic acc;
        int   i, cyc, halt_cycles;

        rst = 1'b1;
        drive(1'b0, 1'b0, idle_ins());
        #1;
        do_reset("rst0");

        // ALU write to rd=5
        x = idle_ins();
        x.pc = 64'h8000_0000; x.rd = 5; x.rd_wen = 1; x.result = 64'h1234;
        step(1, 0, x, acc);
        chk("alu_rf_wen", rf_wen, 1);
        chk("alu_waddr", rf_waddr, 5);
        chk("alu_wdata", rf_wdata, 64'h1234);
        step(0, 0, idle_ins(), acc);
        chk("alu_instret", instret, 1);

        // byte loads at offset 3, signed then unsigned
        x = idle_ins();
        x.pc = 64'h8000_0004; x.rd = 6; x.rd_wen = 1; x.is_load = 1;
        x.size = 0; x.alo = 3; x.ld = 64'h0000_0000_8000_0000;
        step(1, 0, x, acc);
        chk("lb_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        x.uns = 1; x.pc = 64'h8000_0008;
        step(1, 0, x, acc);
        chk("lbu_wdata", rf_wdata, 64'h80);
        chk("lb_no_mis", ld_misaligned, 0);

        // misaligned word load rounds down to offset 0
        x.size = 2; x.uns = 0; x.alo = 2; x.pc = 64'h8000_000c;
        step(1, 0, x, acc);
        chk("lw_mis", ld_misaligned, 1);
        chk("lw_wdata", rf_wdata, 64'hFFFF_FFFF_8000_0000);
        step(0, 0, idle_ins(), acc);

        do_reset("rst1");

        // five back-to-back instructions with a two-cycle hold mid-stream
        i = 0;
        cyc = 0;
        while (i < 5 && cyc < 40) begin
            x = idle_ins();
            x.pc = 64'h100 + 64'(4 * i); x.rd = 5'(i + 1); x.rd_wen = 1;
            x.result = 64'(i * 'h11);
            step(1, (cyc == 2 || cyc == 3), x, acc);
            if (acc) i++;
            cyc++;
        end
        chk("stream_accepted", i, 5);
        step(0, 0, idle_ins(), acc);
        step(0, 0, idle_ins(), acc);
        chk("stream_instret", instret, 5);

        // rd=0 is never written but still retires
        x = idle_ins();
        x.pc = 64'h200; x.rd = 0; x.rd_wen = 1; x.result = 64'hFF;
        step(1, 0, x, acc);
        chk("rd0_rf_wen", rf_wen, 0);
        chk("rd0_fwd_valid", fwd_valid, 0);
        chk("rd0_commit", commit_valid, 1);
        step(0, 0, idle_ins(), acc);
        chk("rd0_instret", instret, 6);

        // ebreak halts; writes its rd; then async reset mid-halt
        x = idle_ins();
        x.pc = 64'h8000_0010; x.rd = 7; x.rd_wen = 1; x.result = 64'h55; x.ebreak = 1;
        step(1, 0, x, acc);
        chk("ebrk_rf_wen", rf_wen, 1);
        chk("ebrk_ready", in_ready, 0);
        step(1, 0, rand_ins(), acc);
        chk("ebrk_halted", halted, 1);
        chk("ebrk_halt_pc", halt_pc, 64'h8000_0010);
        chk("ebrk_instret", instret, 7);
        for (int k = 0; k < 3; k++) step(1, 1'($urandom_range(0, 1)), rand_ins(), acc);
        chk("halt_ready", in_ready, 0);
        do_reset("rst_halt");

        // random traffic
        halt_cycles = 0;
        for (int k = 0; k < 1500; k++) begin
            if (m_halted) halt_cycles++;
            if (halt_cycles > 3) begin
                do_reset("rst_rand");
                halt_cycles = 0;
            end else begin
                step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), rand_ins(), acc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
